rs_multi_cdb: RTL and testbench
===============================

# rs_multi_cdb

Parametrised ALU reservation station. Sits between dispatch (ROB/decoder side) and the integer ALU. Holds up to RS_SIZE in-flight ALU ops and snoops CDB_PORTS completion buses in parallel to capture operands. Issues the oldest ready op through a registered valid/ready port. Slots are allocated and freed in place (no compaction), and age is tracked with an age matrix.

## Interface
- RS_SIZE, 16, number of slots (2..32)
- TAG_W, 5, ROB tag width; tag 0 means "no dependency / value valid"
- XLEN, 32, operand width
- OP_W, 11, opcode field width (passed through unchanged)
- CDB_PORTS, 3, number of completion broadcast buses

Ports:
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low = freeze
- clear  in  1  synchronous flush (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  slot available (combinational from registered state)
- disp_tag  in  TAG_W  destination ROB tag
- disp_op  in  OP_W  opcode
- disp_pc  in  XLEN  instruction PC
- disp_qj, disp_qk  in  TAG_W  producer tags of operands (0 = value valid)
- disp_vj, disp_vk  in  XLEN  operand values, meaningful when the matching q is 0
- cdb_valid  in  CDB_PORTS  per-port broadcast valid
- cdb_tag  in  CDB_PORTS*TAG_W  flattened; port p at [p*TAG_W +: TAG_W]
- cdb_value  in  CDB_PORTS*XLEN  flattened; port p at [p*XLEN +: XLEN]
- iss_valid  out  1  issue register holds an op
- iss_ready  in  1  ALU accepts
- iss_tag, iss_op, iss_pc, iss_vj, iss_vk  out  TAG_W/OP_W/XLEN/XLEN/XLEN  issued op
- count  out  $clog2(RS_SIZE+1)  occupied slots

## Operation
- Per-slot state: valid, tag, op, pc, qj, vj, qk, vk. Plus an age matrix `older[i][j]`, set when slot j was allocated before slot i.
- Dispatch accepted on an edge when disp_valid && disp_ready && rdy_in && !clear. The op is written to the lowest-index free slot. Its older row is set to the current valid vector, and its column is cleared.
- Dispatch bypass: if a cdb port is valid with tag == disp_qj (nonzero) in the same cycle, the slot stores qj=0 and vj=that value. The same applies to qk.
- Wakeup: for each valid slot and operand with q != 0, a matching valid cdb port sets q=0 and v=cdb_value. If several ports match, the lowest port index wins. A cdb tag of 0 never matches.
- Slot ready = valid && qj==0 && qk==0, computed from registered state.
- Select: the ready slot with no older ready slot. The result is unique.
- The issue register loads when !iss_valid || iss_ready. If a ready slot exists, it takes that slot's fields, sets iss_valid=1, and frees the slot on the same edge. Otherwise it sets iss_valid=0.
- disp_ready = (count < RS_SIZE) && rdy_in. A slot freed on the current edge does not raise disp_ready until the next cycle.
- Opcode is not decoded. Operand routing (imm, PC, LUI/AUIPC) is the dispatcher's job.

## Timing
- Reset (rst_in low, asynchronous): all valid=0, age matrix 0, count=0, iss_valid=0, iss_* data=0. disp_ready=1 once rst_in is high and rdy_in is high.
- clear=1 at an edge: all slots invalid, iss_valid=0, count=0. A dispatch in that cycle is dropped. clear takes effect regardless of rdy_in.
- rdy_in=0: no state changes. CDB and dispatch are ignored, and outputs hold their values.
- Dispatch with operands ready, captured at edge N: iss_valid=1 after edge N+1, provided the issue register is free and no older ready op exists.
- CDB wakeup at edge N: the op can be in the issue register at edge N+1. There is no same-edge wakeup-to-issue.
- Backpressure: while iss_valid && !iss_ready, the iss_* outputs are stable and no slot is freed.
- Full: count==RS_SIZE gives disp_ready=0. A dispatch attempted anyway is ignored, with no overwrite.
- Simultaneous dispatch and issue in one cycle: both happen, and count is unchanged.
- count updates at the edge: +1 on dispatch, -1 on issue.

## Test plan
- Reset then single dispatch, tag 3, qj=qk=0, vj=5, vk=7, iss_ready=1 -> iss_valid after 2nd edge with iss_tag=3, iss_vj=5, iss_vk=7. count goes 1 then 0.
- Dependency: dispatch tag 4 with qj=2, then cdb port 1 broadcasts tag 2 value 0x1234 -> iss_vj=0x1234 one edge after the broadcast. Nothing issues before it.
- Age order: dispatch tags 5, 6, 7, all blocked on qj=9. Broadcast tag 9 -> issue order 5, 6, 7 on consecutive edges, despite slot reuse from a prior flush.
- Full: RS_SIZE=4, iss_ready=0, dispatch 5 ops -> disp_ready=0 after the 4th accept (the 5th does not fit). The 5th is dropped, and iss_* stay stable under backpressure.
- Dispatch bypass and multi-port: dispatch qj=8, qk=8 while cdb ports 0 and 2 both carry tag 8 with values 1 and 2 -> vj=vk=1, issue next edge.
- clear with 3 slots valid and iss_valid=1 -> next cycle iss_valid=0, count=0, disp_ready=1. An async rst_in pulse mid-operation produces the same result immediately.

Source files
------------

// File: rtl/rs_multi_cdb_if.sv
`default_nettype none
// ============================================================================
//  Module  : rs_multi_cdb_if
//  Purpose : Bundles the dispatch, completion-broadcast (CDB) and issue buses
//            of the ALU reservation station.
//  Ports   : none (signal bundle only)
//            master modport - producer side (dispatch/CDB driver, ALU sink)
//            slave  modport - reservation station side
//  Revision: 1.0 - initial release
// ============================================================================
interface rs_multi_cdb_if #(
    parameter int TAG_W     = 5,
    parameter int XLEN      = 32,
    parameter int OP_W      = 11,
    parameter int CDB_PORTS = 3
) ();
    // dispatch
    logic                       disp_valid;
    logic                       disp_ready;
    logic [TAG_W-1:0]           disp_tag;
    logic [OP_W-1:0]            disp_op;
    logic [XLEN-1:0]            disp_pc;
    logic [TAG_W-1:0]           disp_qj;
    logic [TAG_W-1:0]           disp_qk;
    logic [XLEN-1:0]            disp_vj;
    logic [XLEN-1:0]            disp_vk;
    // completion broadcast, port p at [p*W +: W]
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_value;
    // issue
    logic                       iss_valid;
    logic                       iss_ready;
    logic [TAG_W-1:0]           iss_tag;
    logic [OP_W-1:0]            iss_op;
    logic [XLEN-1:0]            iss_pc;
    logic [XLEN-1:0]            iss_vj;
    logic [XLEN-1:0]            iss_vk;

    modport master (
        output disp_valid, disp_tag, disp_op, disp_pc, disp_qj, disp_qk, disp_vj, disp_vk,
        input  disp_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  iss_valid, iss_tag, iss_op, iss_pc, iss_vj, iss_vk,
        output iss_ready
    );

    modport slave (
        input  disp_valid, disp_tag, disp_op, disp_pc, disp_qj, disp_qk, disp_vj, disp_vk,
        output disp_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output iss_valid, iss_tag, iss_op, iss_pc, iss_vj, iss_vk,
        input  iss_ready
    );
endinterface
`default_nettype wire

// File: rtl/rs_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module  : rs_multi_cdb
//  Purpose : ALU reservation station. Holds up to RS_SIZE ops, snoops
//            CDB_PORTS completion buses for operands, and issues the oldest
//            ready op through a registered valid/ready port. Slots are
//            allocated/freed in place; age is kept in an age matrix.
//  Ports   : clk_in  - clock (rising edge)
//            rst_in  - asynchronous reset, active low
//            rdy_in  - global enable, low freezes all state
//            clear   - synchronous flush
//            count   - occupied slot count
//            bus     - dispatch / CDB / issue bundle (slave side)
//  Revision: 1.0 - initial release
// ============================================================================
module rs_multi_cdb #(
    parameter int RS_SIZE   = 16,
    parameter int TAG_W     = 5,
    parameter int XLEN      = 32,
    parameter int OP_W      = 11,
    parameter int CDB_PORTS = 3
) (
    input  wire logic                         clk_in,
    input  wire logic                         rst_in,
    input  wire logic                         rdy_in,
    input  wire logic                         clear,
    output logic [$clog2(RS_SIZE+1)-1:0]      count,
    rs_multi_cdb_if.slave                     bus
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [CNT_W-1:0] c_RS_FULL = CNT_W'(RS_SIZE);

    // slot state
    logic [RS_SIZE-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [RS_SIZE];
    logic [OP_W-1:0]    r_op  [RS_SIZE];
    logic [XLEN-1:0]    r_pc  [RS_SIZE];
    logic [TAG_W-1:0]   r_qj  [RS_SIZE];
    logic [TAG_W-1:0]   r_qk  [RS_SIZE];
    logic [XLEN-1:0]    r_vj  [RS_SIZE];
    logic [XLEN-1:0]    r_vk  [RS_SIZE];
    // r_older[i][j] = 1 when slot j was allocated before slot i
    logic [RS_SIZE-1:0] r_older [RS_SIZE];
    logic [CNT_W-1:0]   r_count;

    logic               r_iss_valid;
    logic [TAG_W-1:0]   r_iss_tag;
    logic [OP_W-1:0]    r_iss_op;
    logic [XLEN-1:0]    r_iss_pc;
    logic [XLEN-1:0]    r_iss_vj;
    logic [XLEN-1:0]    r_iss_vk;

    // Snoop result: {hit, value}. Lowest port index wins; tag 0 never matches.
    function automatic logic [XLEN:0] f_snoop(
        input logic [TAG_W-1:0]           q,
        input logic [CDB_PORTS-1:0]       vld,
        input logic [CDB_PORTS*TAG_W-1:0] tags,
        input logic [CDB_PORTS*XLEN-1:0]  vals
    );
        logic [XLEN:0] hit;
        hit = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (vld[p] && (q != '0) && (tags[p*TAG_W +: TAG_W] == q))
                hit = {1'b1, vals[p*XLEN +: XLEN]};
        end
        return hit;
    endfunction

    logic [XLEN:0]      w_snj [RS_SIZE];
    logic [XLEN:0]      w_snk [RS_SIZE];
    logic [XLEN:0]      w_sdj;
    logic [XLEN:0]      w_sdk;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_sel;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_any_ready;
    logic               w_disp_ready;
    logic               w_disp_fire;
    logic               w_iss_load;
    logic               w_iss_fire;

    always_comb begin
        w_sel_idx  = '0;
        w_free_idx = '0;
        w_sdj = f_snoop(bus.disp_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        w_sdk = f_snoop(bus.disp_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        for (int i = 0; i < RS_SIZE; i++) begin
            w_snj[i]   = f_snoop(r_qj[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            w_snk[i]   = f_snoop(r_qk[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            w_ready[i] = r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
        // A ready slot with no older ready slot; age matrix makes it unique.
        for (int i = 0; i < RS_SIZE; i++)
            w_sel[i] = w_ready[i] && ((r_older[i] & w_ready) == '0);
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_sel[i])    w_sel_idx  = IDX_W'(i);
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign w_any_ready  = |w_ready;
    // Uses the registered count, so a slot freed this edge is not reusable yet.
    assign w_disp_ready = (r_count < c_RS_FULL) && rdy_in;
    assign w_disp_fire  = bus.disp_valid && w_disp_ready && !clear;
    assign w_iss_load   = !r_iss_valid || bus.iss_ready;
    assign w_iss_fire   = w_iss_load && w_any_ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_tag   <= '0;
            r_iss_op    <= '0;
            r_iss_pc    <= '0;
            r_iss_vj    <= '0;
            r_iss_vk    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_older[i] <= '0;
                r_tag[i]   <= '0;
                r_op[i]    <= '0;
                r_pc[i]    <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
            end
        end else if (clear) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            for (int i = 0; i < RS_SIZE; i++)
                r_older[i] <= '0;
        end else if (rdy_in) begin
            // operand wakeup
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_valid[i]) begin
                    if (w_snj[i][XLEN]) begin
                        r_qj[i] <= '0;
                        r_vj[i] <= w_snj[i][XLEN-1:0];
                    end
                    if (w_snk[i][XLEN]) begin
                        r_qk[i] <= '0;
                        r_vk[i] <= w_snk[i][XLEN-1:0];
                    end
                end
            end
            // issue register
            if (w_iss_load) begin
                r_iss_valid <= w_any_ready;
                if (w_any_ready) begin
                    r_valid[w_sel_idx] <= 1'b0;
                    r_iss_tag <= r_tag[w_sel_idx];
                    r_iss_op  <= r_op[w_sel_idx];
                    r_iss_pc  <= r_pc[w_sel_idx];
                    r_iss_vj  <= r_vj[w_sel_idx];
                    r_iss_vk  <= r_vk[w_sel_idx];
                end
            end
            // allocation into the lowest free slot (never the issuing one)
            if (w_disp_fire) begin
                r_valid[w_free_idx] <= 1'b1;
                r_tag[w_free_idx]   <= bus.disp_tag;
                r_op[w_free_idx]    <= bus.disp_op;
                r_pc[w_free_idx]    <= bus.disp_pc;
                r_qj[w_free_idx]    <= w_sdj[XLEN] ? '0 : bus.disp_qj;
                r_vj[w_free_idx]    <= w_sdj[XLEN] ? w_sdj[XLEN-1:0] : bus.disp_vj;
                r_qk[w_free_idx]    <= w_sdk[XLEN] ? '0 : bus.disp_qk;
                r_vk[w_free_idx]    <= w_sdk[XLEN] ? w_sdk[XLEN-1:0] : bus.disp_vk;
                // stale column bits from a previous occupant are wiped here
                for (int k = 0; k < RS_SIZE; k++)
                    r_older[k][w_free_idx] <= 1'b0;
                r_older[w_free_idx] <= r_valid;
            end
            r_count <= r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);
        end
    end

    assign count          = r_count;
    assign bus.disp_ready = w_disp_ready;
    assign bus.iss_valid  = r_iss_valid;
    assign bus.iss_tag    = r_iss_tag;
    assign bus.iss_op     = r_iss_op;
    assign bus.iss_pc     = r_iss_pc;
    assign bus.iss_vj     = r_iss_vj;
    assign bus.iss_vk     = r_iss_vk;
endmodule
`default_nettype wire

// File: tb/tb_rs_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rs_multi_cdb
//  Purpose : Scoreboard bench for rs_multi_cdb. A queue-based age-ordered
//            reference model predicts issued ops and occupancy; a monitor
//            compares the DUT against it every cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rs_multi_cdb;
    localparam int RS_SIZE   = 4;
    localparam int TAG_W     = 5;
    localparam int XLEN      = 32;
    localparam int OP_W      = 11;
    localparam int CDB_PORTS = 3;
    localparam int CNT_W     = $clog2(RS_SIZE + 1);

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clear;
    logic [CNT_W-1:0] count;

    logic                       disp_valid;
    logic [TAG_W-1:0]           disp_tag, disp_qj, disp_qk;
    logic [OP_W-1:0]            disp_op;
    logic [XLEN-1:0]            disp_pc, disp_vj, disp_vk;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_value;
    logic                       iss_ready;

    rs_multi_cdb_if #(.TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)) bus ();

    assign bus.disp_valid = disp_valid;
    assign bus.disp_tag   = disp_tag;
    assign bus.disp_op    = disp_op;
    assign bus.disp_pc    = disp_pc;
    assign bus.disp_qj    = disp_qj;
    assign bus.disp_qk    = disp_qk;
    assign bus.disp_vj    = disp_vj;
    assign bus.disp_vk    = disp_vk;
    assign bus.cdb_valid  = cdb_valid;
    assign bus.cdb_tag    = cdb_tag;
    assign bus.cdb_value  = cdb_value;
    assign bus.iss_ready  = iss_ready;

    rs_multi_cdb #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W),
                   .CDB_PORTS(CDB_PORTS)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .count  (count),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
    } ent_t;

    ent_t ents[$];   // waiting ops, oldest first
    ent_t expq[$];   // op expected in the issue register
    bit   m_iss_valid;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // lowest valid CDB port carrying tag q, or -1; tag 0 never matches
    function automatic int cdb_port(input logic [TAG_W-1:0] q);
        if (q == '0) return -1;
        for (int p = 0; p < CDB_PORTS; p++)
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == q) return p;
        return -1;
    endfunction

    function automatic logic [XLEN-1:0] cdb_val(input int p);
        return cdb_value[p*XLEN +: XLEN];
    endfunction

    // reference model
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ents.delete();
            expq.delete();
            m_iss_valid = 1'b0;
        end else if (clear) begin
            ents.delete();
            expq.delete();
            m_iss_valid = 1'b0;
        end else if (rdy_in) begin
            int   sel;
            int   n0;
            int   p;
            ent_t e;
            n0  = ents.size();
            sel = -1;
            // readiness is judged on pre-wakeup state
            for (int i = 0; i < ents.size(); i++)
                if (sel < 0 && ents[i].qj == '0 && ents[i].qk == '0) sel = i;
            for (int i = 0; i < ents.size(); i++) begin
                e = ents[i];
                p = cdb_port(e.qj);
                if (p >= 0) begin e.qj = '0; e.vj = cdb_val(p); end
                p = cdb_port(e.qk);
                if (p >= 0) begin e.qk = '0; e.vk = cdb_val(p); end
                ents[i] = e;
            end
            if (!m_iss_valid || iss_ready) begin
                if (sel >= 0) begin
                    expq.push_back(ents[sel]);
                    ents.delete(sel);
                    m_iss_valid = 1'b1;
                end else begin
                    m_iss_valid = 1'b0;
                end
            end
            if (disp_valid && n0 < RS_SIZE) begin
                e.tag = disp_tag; e.op = disp_op; e.pc = disp_pc;
                e.qj = disp_qj; e.vj = disp_vj; e.qk = disp_qk; e.vk = disp_vk;
                p = cdb_port(disp_qj);
                if (p >= 0) begin e.qj = '0; e.vj = cdb_val(p); end
                p = cdb_port(disp_qk);
                if (p >= 0) begin e.qk = '0; e.vk = cdb_val(p); end
                ents.push_back(e);
            end
        end
    end

    // monitor
    always @(negedge clk_in) begin
        if (rst_in === 1'b1) begin
            chk("count", count, ents.size());
            chk("disp_ready", bus.disp_ready, rdy_in && (ents.size() < RS_SIZE));
            chk("iss_valid", bus.iss_valid, expq.size() != 0);
            if (bus.iss_valid && expq.size() != 0) begin
                chk("iss_fields", {bus.iss_tag, bus.iss_op, bus.iss_pc, bus.iss_vj, bus.iss_vk},
                    {expq[0].tag, expq[0].op, expq[0].pc, expq[0].vj, expq[0].vk});
                if (iss_ready && rdy_in && !clear) void'(expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        clear      = 1'b0;
    endtask

    task automatic dispatch(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] qj,
                            input logic [TAG_W-1:0] qk, input logic [XLEN-1:0] vj,
                            input logic [XLEN-1:0] vk);
        disp_valid = 1'b1;
        disp_tag   = t;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_op    = OP_W'($urandom());
        disp_pc    = $urandom();
    endtask

    task automatic bcast(input int p, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_valid[p]                 = 1'b1;
        cdb_tag[p*TAG_W +: TAG_W]    = t;
        cdb_value[p*XLEN +: XLEN]    = v;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; iss_ready = 1'b1;
        idle();
        dispatch('0, '0, '0, '0, '0);
        disp_valid = 1'b0;
        cdb_tag = '0; cdb_value = '0;
        tick(); tick();
        rst_in = 1'b1;
        chk("reset_iss_data", {bus.iss_tag, bus.iss_op, bus.iss_pc, bus.iss_vj, bus.iss_vk}, '0);
        chk("reset_count", count, 0);

        // single ready op: tag 3
        dispatch(5'd3, '0, '0, 32'd5, 32'd7);
        tick(); idle();
        chk("single_count1", count, 1);
        tick();
        chk("single_issue", {bus.iss_valid, bus.iss_tag, bus.iss_vj, bus.iss_vk},
            {1'b1, 5'd3, 32'd5, 32'd7});
        chk("single_count0", count, 0);
        tick();

        // dependency wakeup via port 1
        dispatch(5'd4, 5'd2, '0, '0, 32'd9);
        tick(); idle(); tick(); tick();
        chk("dep_no_early", bus.iss_valid, 1'b0);
        bcast(1, 5'd2, 32'h1234);
        tick(); idle(); tick();
        chk("dep_issue", {bus.iss_valid, bus.iss_tag, bus.iss_vj}, {1'b1, 5'd4, 32'h1234});
        tick();

        // age order after flush and slot reuse
        dispatch(5'd10, 5'd15, '0, '0, '0); tick();
        dispatch(5'd11, 5'd15, '0, '0, '0); tick();
        idle(); clear = 1'b1; tick(); clear = 1'b0;
        dispatch(5'd5, 5'd9, '0, '0, '0); tick();
        dispatch(5'd6, 5'd9, '0, '0, '0); tick();
        dispatch(5'd7, 5'd9, '0, '0, '0); tick();
        idle(); bcast(0, 5'd9, 32'hABCD); tick(); idle();
        tick(); chk("age_first", bus.iss_tag, 5'd5);
        tick(); chk("age_second", bus.iss_tag, 5'd6);
        tick(); chk("age_third", bus.iss_tag, 5'd7);
        tick(); tick();

        // full with backpressure
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dispatch(5'(21 + k), 5'd20, '0, '0, '0);
            tick();
        end
        chk("full_ready", bus.disp_ready, 1'b0);
        chk("full_count", count, 4);
        dispatch(5'd25, 5'd20, '0, '0, '0);
        tick(); idle();
        chk("full_drop_count", count, 4);
        bcast(2, 5'd20, 32'h55); tick(); idle();
        tick(); tick(); tick();
        chk("bp_hold_tag", bus.iss_tag, 5'd21);
        iss_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // dispatch bypass, two ports carrying the same tag
        dispatch(5'd12, 5'd8, 5'd8, '0, '0);
        bcast(0, 5'd8, 32'd1);
        bcast(2, 5'd8, 32'd2);
        tick(); idle(); tick();
        chk("bypass_issue", {bus.iss_valid, bus.iss_tag, bus.iss_vj, bus.iss_vk},
            {1'b1, 5'd12, 32'd1, 32'd1});
        tick();

        // clear with occupied slots and a held issue register
        iss_ready = 1'b0;
        dispatch(5'd13, '0, '0, 32'd1, 32'd2); tick();
        for (int k = 0; k < 3; k++) begin
            dispatch(5'(14 + k), 5'd30, '0, '0, '0);
            tick();
        end
        idle(); tick();
        chk("pre_clear_count", count, 3);
        clear = 1'b1;
        dispatch(5'd17, '0, '0, '0, '0);
        tick(); idle();
        chk("clear_state", {bus.iss_valid, count, bus.disp_ready}, {1'b0, 3'd0, 1'b1});
        dispatch(5'd18, '0, '0, 32'd3, 32'd4); tick();
        for (int k = 0; k < 3; k++) begin
            dispatch(5'(19 + k), 5'd30, '0, '0, '0);
            tick();
        end
        idle(); tick();
        #3 rst_in = 1'b0;
        #1 chk("async_reset", {bus.iss_valid, count, bus.disp_ready}, {1'b0, 3'd0, 1'b1});
        tick();
        rst_in = 1'b1;
        iss_ready = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy_in     = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 59) == 0);
            iss_ready  = ($urandom_range(0, 3) != 0);
            dispatch(5'($urandom_range(1, 31)),
                     ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 6)),
                     ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 6)),
                     $urandom(), $urandom());
            disp_valid = ($urandom_range(0, 1) == 1);
            cdb_valid  = '0;
            for (int p = 0; p < CDB_PORTS; p++)
                if ($urandom_range(0, 2) == 0) bcast(p, 5'($urandom_range(0, 6)), $urandom());
            tick();
        end
        idle(); rdy_in = 1'b1; iss_ready = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
